nested_loop_counter: RTL
========================

Name: nested_loop_counter

Overview:
- Multi-dimensional, run-time-programmable loop index generator. It replaces the single-dimension up counter used to sequence CNN/FIR layers.
- Produces NUM_DIMS nested indices (dimension 0 innermost), each counting 0..max inclusive.
- Advances only while en_i is high, so the consumer can stall it.
- Supports one-shot and continuous (auto-restart) modes and flags the last beat and per-dimension wrap points, which drive address generators and accumulator flushes.

Parameters:
- WORD_SIZE, 16, width of each index and each max field.
- NUM_DIMS, 3, number of nested dimensions (>=1).
- CONTINUOUS, 0, 0 = stop after the final beat; 1 = wrap to all-zero and keep counting.

Ports:
- clk_i  input  1  clock, rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- start_i  input  1  begin a sequence; sampled in IDLE only.
- clear_i  input  1  synchronous abort to IDLE, no done_o pulse.
- en_i  input  1  advance enable; the current beat is consumed on a clock edge where valid_o && en_i.
- max_i  input  NUM_DIMS*WORD_SIZE  inclusive upper bound per dimension; field k is bits [k*WORD_SIZE +: WORD_SIZE]; latched on start.
- data_o  output  NUM_DIMS*WORD_SIZE  current indices; same packing as max_i.
- valid_o  output  1  data_o holds a live beat.
- wrap_o  output  NUM_DIMS  wrap_o[k] = valid_o && index j == max j for all j<=k.
- last_o  output  1  equals wrap_o[NUM_DIMS-1]; marks the final beat of the sequence.
- busy_o  output  1  high in COUNT.
- done_o  output  1  one-cycle pulse, registered, in the cycle after the final beat is consumed.

Behaviour:
- States: IDLE, COUNT.
- Reset (async, on assertion): state IDLE; data_o=0, valid_o=0, busy_o=0, done_o=0; latched max=0.
- IDLE:
  - valid_o=0 and data_o=0.
  - start_i=1 at an edge: latch max_i, clear all indices, go to COUNT.
  - Start latency is one cycle: valid_o=1 with data_o=all-zero in the cycle after start_i.
- COUNT:
  - valid_o=1, busy_o=1.
  - en_i=0: indices hold; no flags change.
  - en_i=1, not last: index 0 increments. Where wrap_o[k-1]=1 (k>=1), index k-1 returns to 0 and index k increments. A carry therefore ripples through every dimension whose lower dimensions are all at max.
  - en_i=1, last_o=1, CONTINUOUS=0: go to IDLE; data_o=0; valid_o=0; done_o=1 for exactly one cycle.
  - en_i=1, last_o=1, CONTINUOUS=1: all indices go to 0 and the block stays in COUNT; done_o pulses for one cycle, marking the sequence boundary.
- Beat count per sequence = product over k of (max_k+1).
- max_k=0: that dimension is constant 0 and always satisfies its wrap term. All-zero max gives a one-beat sequence with last_o=1 immediately.
- Index arithmetic is unsigned WORD_SIZE-bit. An index never exceeds its latched max, so there is no overflow path. max_k = 2^WORD_SIZE-1 is legal and wraps naturally.
- start_i in COUNT is ignored. max_i changes after start have no effect until the next start.
- clear_i has priority over start_i and en_i: next state IDLE, indices 0, valid_o=0, no done_o pulse. clear_i in IDLE is a no-op.
- start_i and clear_i in the same IDLE cycle: clear wins and the block stays IDLE.
- Same-edge restart: start_i asserted in the cycle done_o is high (already IDLE) starts the next sequence normally. No dead cycle is required beyond the done cycle.
- Reset asserted mid-sequence aborts immediately (asynchronously) to the reset values. No done_o pulse.
- wrap_o and last_o are combinational from the registered indices and the latched max. done_o, valid_o, busy_o and data_o are registered.

Test Plan:
- One-shot traversal: NUM_DIMS=3, max=(1,2,1) for dims 0,1,2, en_i=1, start 1 cycle -> 12 beats, indices (d0,d1,d2) go (0,0,0),(1,0,0),(0,1,0)...(1,2,1). wrap_o[0] high on every d0=1; last_o only on (1,2,1); done_o 1 cycle later; valid_o drops with it.
- Stall: max=(3,0,0), en_i toggled 1,0,0,1,1,0,1 -> indices 0,1,1,1,2,3,3,then done. Indices and flags are frozen while en_i=0; exactly 4 beats are consumed.
- Continuous mode: CONTINUOUS=1, max=(2,0,0), en_i=1 for 9 cycles -> data 0,1,2,0,1,2,0,1,2. done_o pulses 3 times; busy_o stays high throughout.
- Degenerate: max=all-zero, start -> one beat with data 0 and last_o=1 on the first valid cycle. done_o follows; beats consumed = 1.
- Abort/ignore:
  - clear_i at beat 5 of 12 -> IDLE next cycle, no done_o.
  - start_i during COUNT with a different max_i -> sequence continues on the original max.
  - start_i+clear_i together in IDLE -> stays IDLE.
- Async reset: assert reset_i between clock edges mid-sequence -> all outputs 0 before the next edge. After release, start runs a clean sequence from 0.

Source files
------------

// File: rtl/nested_loop_counter.sv
// Run-time programmable nested loop index generator.
// Dimension 0 is innermost; every index counts 0..max inclusive.
module nested_loop_counter #(
  parameter int WORD_SIZE  = 16,
  parameter int NUM_DIMS   = 3,
  parameter int CONTINUOUS = 0
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          start_i,
  input  logic                          clear_i,
  input  logic                          en_i,
  input  logic [NUM_DIMS*WORD_SIZE-1:0] max_i,
  output logic [NUM_DIMS*WORD_SIZE-1:0] data_o,
  output logic                          valid_o,
  output logic [NUM_DIMS-1:0]           wrap_o,
  output logic                          last_o,
  output logic                          busy_o,
  output logic                          done_o
);

  typedef enum logic {
    IDLE,
    COUNT
  } state_t;

  typedef logic [NUM_DIMS-1:0][WORD_SIZE-1:0] vec_t;

  state_t              state;
  state_t              state_n;
  vec_t                idx;
  vec_t                idx_n;
  vec_t                lim;
  vec_t                lim_n;
  logic                done;
  logic                done_n;
  logic [NUM_DIMS-1:0] wrap;
  logic                last;

  // wrap[k]: live beat and every dimension 0..k sits at its max
  always_comb begin
    logic acc;
    acc = (state == COUNT);
    for (int k = 0; k < NUM_DIMS; k++) begin
      acc     = acc & (idx[k] == lim[k]);
      wrap[k] = acc;
    end
  end

  assign last = wrap[NUM_DIMS-1];

  always_comb begin
    logic carry;
    state_n = state;
    idx_n   = idx;
    lim_n   = lim;
    done_n  = 1'b0;
    carry   = 1'b1;
    unique case (state)
      IDLE: begin
        if (!clear_i && start_i) begin
          lim_n   = max_i;
          idx_n   = '0;
          state_n = COUNT;
        end
      end
      COUNT: begin
        if (clear_i) begin
          idx_n   = '0;
          state_n = IDLE;
        end else if (en_i) begin
          if (last) begin
            idx_n  = '0;
            done_n = 1'b1;
            if (CONTINUOUS == 0) begin
              state_n = IDLE;
            end
          end else begin
            // carry into k only when all lower dimensions wrap
            for (int k = 0; k < NUM_DIMS; k++) begin
              if (carry) begin
                idx_n[k] = wrap[k] ? '0 : idx[k] + WORD_SIZE'(1);
              end
              carry = wrap[k];
            end
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= IDLE;
      idx   <= '0;
      lim   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      lim   <= lim_n;
      done  <= done_n;
    end
  end

  assign data_o  = idx;
  assign valid_o = (state == COUNT);
  assign busy_o  = (state == COUNT);
  assign done_o  = done;
  assign wrap_o  = wrap;
  assign last_o  = last;

endmodule
